// File: rtl/pixel_serializer.sv
// pixel_serializer: parallel word in, one bit per shift_en out.
// Valid/ready upstream; zero-bubble reload on the final bit of a word.
module pixel_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             c,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             load, adv, done;

  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign last      = busy && (cnt == CNT_LAST);
  assign out_bit   = busy &&
                     (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign in_ready  = !busy || (last && shift_en);

  // load only reaches SHIFT state when last && shift_en,
  // so the three cases below are mutually exclusive
  assign load = in_valid && in_ready;
  assign adv  = busy && shift_en && !last;
  assign done = busy && shift_en && last && !load;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    unique case (1'b1)
      load: begin
        state_nx = SHIFT;
        shreg_nx = in_data;
        cnt_nx   = '0;
      end
      adv: begin
        shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        cnt_nx   = cnt + CW'(1);
      end
      done: begin
        state_nx = IDLE;
        shreg_nx = '0;
        cnt_nx   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// tb_pixel_serializer: three serializer instances against a
// bit-sequence reference model; directed steps then random traffic.
module tb_pixel_serializer;

  logic       c = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       shift_en;

  logic rdy[3], ob[3], ov[3], lst[3], bsy[3];

  int total = 0;
  int bad   = 0;

  // model: remaining bits of the current word, in emission order
  bit seq[3][8];
  int pos[3];
  int rem[3];

  logic s0, l0, r0;

  always #5 c = ~c;

  pixel_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (
    .c(c), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .shift_en(shift_en), .out_bit(ob[0]),
    .out_valid(ov[0]), .last(lst[0]), .busy(bsy[0])
  );

  pixel_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u8l (
    .c(c), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .shift_en(shift_en), .out_bit(ob[1]),
    .out_valid(ov[1]), .last(lst[1]), .busy(bsy[1])
  );

  pixel_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u1 (
    .c(c), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data[0:0]), .shift_en(shift_en), .out_bit(ob[2]),
    .out_valid(ov[2]), .last(lst[2]), .busy(bsy[2])
  );

  function automatic int wid(int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic bit mready(int k);
    return (rem[k] == 0) || (rem[k] == 1 && shift_en);
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 3; k++) begin
      bit b;
      bit o;
      b = rem[k] > 0;
      o = b ? seq[k][pos[k]] : 1'b0;
      chk($sformatf("busy%0d", k), bsy[k], b);
      chk($sformatf("valid%0d", k), ov[k], b);
      chk($sformatf("bit%0d", k), ob[k], o);
      chk($sformatf("last%0d", k), lst[k], rem[k] == 1);
      chk($sformatf("ready%0d", k), rdy[k], mready(k));
    end
  endtask

  task automatic step();
    for (int k = 0; k < 3; k++) begin
      bit ld;
      if (rst) begin
        rem[k] = 0;
        pos[k] = 0;
      end else begin
        ld = in_valid && mready(k);
        if (rem[k] > 0 && shift_en) begin
          rem[k]--;
          pos[k]++;
        end
        if (ld) begin
          for (int i = 0; i < wid(k); i++)
            seq[k][i] = (k == 1) ? in_data[i]
                                 : in_data[wid(k)-1-i];
          pos[k] = 0;
          rem[k] = wid(k);
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    chk_all();
    s0 = ob[0];
    l0 = lst[0];
    r0 = rdy[0];
    @(posedge c);
    step();
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    shift_en = 1'b1;
    repeat (n) cyc();
  endtask

  logic [7:0]  sb, lm;
  logic [15:0] s16;
  logic [14:0] rm;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      pos[k] = 0;
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    shift_en = 1'b1;
    @(posedge c);
    step();
    #1;
    repeat (2) cyc();
    rst = 1'b0;
    idle(1);

    // single word 0xB4, continuous shift
    in_valid = 1'b1;
    in_data = 8'hB4;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      sb = {sb[6:0], s0};
      lm[i] = l0;
    end
    chk("b4_stream", sb === 8'hB4, 1'b1);
    chk("b4_lastpos", lm === 8'h80, 1'b1);
    idle(2);

    // back-to-back 0xF0 then 0x0F
    in_valid = 1'b1;
    in_data = 8'hF0;
    cyc();
    in_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 8);
      cyc();
      s16 = {s16[14:0], s0};
      if (i < 15) rm[i] = r0;
    end
    chk("b2b_stream", s16 === 16'hF00F, 1'b1);
    chk("b2b_ready", rm === 15'h0080, 1'b1);
    idle(2);

    // throttled shift, LSB-first instance sees 0x01
    in_valid = 1'b1;
    in_data = 8'h01;
    shift_en = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 27; i++) begin
      shift_en = (i % 3 == 2);
      cyc();
    end
    idle(2);

    // mid-word reset, then a fresh 0x80
    in_valid = 1'b1;
    in_data = 8'hFF;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    in_valid = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1;
    in_data = 8'h80;
    cyc();
    in_valid = 1'b0;
    repeat (10) cyc();

    // width-1 words 1,0,1 back to back
    in_valid = 1'b1;
    in_data = 8'h01;
    cyc();
    in_data = 8'h00;
    cyc();
    in_data = 8'h01;
    cyc();
    idle(10);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 2) != 0;
      in_data = 8'($urandom);
      shift_en = $urandom_range(0, 3) != 0;
      cyc();
    end
    rst = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
